// File: rtl/wait_state_memory.sv
// -----------------------------------------------------------------------------
// wait_state_memory
//
// Single-port word-addressed memory with a request/ready handshake, a
// programmable number of wait states, byte-lane write enables and separate
// read/write data buses. One access is in flight at a time. On reset the
// array reloads the 10-word boot image at word 0 and clears every other word.
//
// Optional feature, selected by the macro MEM_RANGE_CHECK_EN:
//   defined   - a captured address >= DEPTH completes with m_err=1 alongside
//               m_ready. Nothing is written, and a read returns 0.
//   undefined - the address wraps to its low $clog2(DEPTH) bits, and m_err
//               is tied to 0.
// -----------------------------------------------------------------------------
module wait_state_memory #(
    parameter int DW          = 32,  // data width, multiple of 8
    parameter int AW          = 12,  // word address width
    parameter int DEPTH       = 32,  // number of words, 16..2**AW
    parameter int WAIT_STATES = 2    // extra cycles before completion, 0..15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                m_req,
    input  logic                m_rw_,
    input  logic [AW-1:0]       m_addr,
    input  logic [DW-1:0]       m_wdata,
    input  logic [DW/8-1:0]     m_be,
    output logic [DW-1:0]       m_rdata,
    output logic                m_ready,
    output logic                m_busy,
    output logic                m_err
);

    localparam int NB = DW / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] WS_LOAD     = CW'(WAIT_STATES);
    localparam int            BOOT_WORDS  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Boot image word for a given index; zero-extended or truncated to DW.
    function automatic logic [DW-1:0] boot_word(input int idx);
        logic [31:0]   img;
        logic [DW-1:0] w;
        case (idx)
            0:       img = 32'h2800_0001;
            1:       img = 32'h2000_9000;
            2:       img = 32'h1200_0004;
            3:       img = 32'h4800_1001;
            4:       img = 32'h7800_1000;
            5:       img = 32'h1800_0007;
            6:       img = 32'h1000_0002;
            7:       img = 32'h3000_100A;
            8:       img = 32'h9FFF_FFFF;
            9:       img = 32'h5555_AAAA;
            default: img = 32'h0000_0000;
        endcase
        w = '0;
        for (int b = 0; b < DW && b < 32; b++) begin
            w[b] = img[b];
        end
        return w;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept;
    logic            complete;

    logic            rw_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [NB-1:0]   be_q;

    logic [DW-1:0]   mem [DEPTH];

    logic [IW-1:0]   idx;
    logic            in_range;
    logic            err_d;
    logic            do_read;
    logic            do_write;
    logic            unused_addr;

    // State and wait counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, complete at zero.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    accept  = 1'b1;
                    cnt_d   = WS_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    assign m_busy = (state_q == BUSY);

    // Request capture: later bus changes while BUSY must not reach the access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            rw_q    <= m_rw_;
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            be_q    <= m_be;
        end
    end

    assign idx = addr_q[IW-1:0];

`ifdef MEM_RANGE_CHECK_EN
    // Out-of-range addresses are flagged instead of wrapping.
    assign in_range = ({1'b0, addr_q} < (AW + 1)'(DEPTH));
    assign err_d    = ~in_range;
`else
    // Address wraps. The guard only matters for non-power-of-two depths.
    assign in_range = ({1'b0, idx} < (IW + 1)'(DEPTH));
    assign err_d    = 1'b0;
`endif

    // Upper address bits are unused when the address wraps.
    assign unused_addr = ^addr_q;

    assign do_read  = complete &  rw_q;
    assign do_write = complete & ~rw_q & in_range;

    // Storage array: the boot image on reset, byte-lane writes at completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: this array is built from flops and must be reset. The boot
            // image is part of its function, and a reset during an access
            // has to restore it.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= boot_word(i);
            end
        end else if (do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Registered read data. It holds until the next read completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rdata <= '0;
        end else if (do_read) begin
            m_rdata <= in_range ? mem[idx] : '0;
        end
    end

    // One-cycle completion and error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ready <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_ready <= complete;
            m_err   <= complete & err_d;
        end
    end

endmodule

// File: tb/tb_wait_state_memory.sv
// -----------------------------------------------------------------------------
// tb_wait_state_memory
//
// Two instances share clock and reset: unit 0 has WAIT_STATES=2 and unit 1 has
// WAIT_STATES=0. A behavioural model (one word array per unit plus the last
// read value) predicts data, latency and the error flag. The bench follows
// MEM_RANGE_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_wait_state_memory;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 32;
    localparam int NB    = DW / 8;
    localparam int WS0   = 2;
    localparam int WS1   = 0;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            req   [2];
    logic            rw_   [2];
    logic [AW-1:0]   addr  [2];
    logic [DW-1:0]   wdata [2];
    logic [NB-1:0]   be    [2];
    logic [DW-1:0]   rdata [2];
    logic            ready [2];
    logic            busy  [2];
    logic            err   [2];

    logic [31:0]     model   [2][DEPTH];
    logic [31:0]     last_rd [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    wait_state_memory #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut_ws2 (
        .clock   (clock),
        .reset   (reset),
        .m_req   (req[0]),
        .m_rw_   (rw_[0]),
        .m_addr  (addr[0]),
        .m_wdata (wdata[0]),
        .m_be    (be[0]),
        .m_rdata (rdata[0]),
        .m_ready (ready[0]),
        .m_busy  (busy[0]),
        .m_err   (err[0])
    );

    wait_state_memory #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut_ws0 (
        .clock   (clock),
        .reset   (reset),
        .m_req   (req[1]),
        .m_rw_   (rw_[1]),
        .m_addr  (addr[1]),
        .m_wdata (wdata[1]),
        .m_be    (be[1]),
        .m_rdata (rdata[1]),
        .m_ready (ready[1]),
        .m_busy  (busy[1]),
        .m_err   (err[1])
    );

    function automatic int ws_of(input int u);
        return (u == 0) ? WS0 : WS1;
    endfunction

    function automatic logic [31:0] boot(input int i);
        logic [31:0] img [10];
        img = '{32'h28000001, 32'h20009000, 32'h12000004, 32'h48001001, 32'h78001000,
                32'h18000007, 32'h10000002, 32'h3000100A, 32'h9FFFFFFF, 32'h5555AAAA};
        return (i < 10) ? img[i] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic init_model();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < DEPTH; i++) model[u][i] = boot(i);
            last_rd[u] = 32'h0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            for (int u = 0; u < 2; u++) begin
                check("idle_ready", ready[u], 1'b0);
                check("idle_busy", busy[u], 1'b0);
            end
        end
    endtask

    // Runs one access on unit u and checks every cycle up to the completion pulse.
    task automatic do_access(input int u, input bit rw, input logic [AW-1:0] a,
                             input logic [31:0] wd, input logic [NB-1:0] b,
                             input bit hold, output logic [31:0] got);
        int ws;
        int idx;
        bit inr;
        ws  = ws_of(u);
        idx = int'(a) % DEPTH;
`ifdef MEM_RANGE_CHECK_EN
        inr = (int'(a) < DEPTH);
`else
        inr = 1'b1;
`endif
        if (rw) last_rd[u] = inr ? model[u][idx] : 32'h0;
        else if (inr)
            for (int i = 0; i < NB; i++)
                if (b[i]) model[u][idx][8*i +: 8] = wd[8*i +: 8];

        @(negedge clock);
        req[u] = 1'b1; rw_[u] = rw; addr[u] = a; wdata[u] = wd; be[u] = b;
        @(posedge clock); #1;
        check("accept_busy", busy[u], 1'b1);
        check("accept_ready", ready[u], 1'b0);
        if (!hold) req[u] = 1'b0;
        addr[u]  = AW'($urandom);
        wdata[u] = $urandom;
        be[u]    = NB'($urandom);
        rw_[u]   = 1'($urandom_range(0, 1));
        for (int c = 1; c <= ws; c++) begin
            @(posedge clock); #1;
            check("wait_busy", busy[u], 1'b1);
            check("wait_ready", ready[u], 1'b0);
            check("wait_err", err[u], 1'b0);
        end
        @(posedge clock); #1;
        check("done_ready", ready[u], 1'b1);
        check("done_busy", busy[u], 1'b0);
        check("done_err", err[u], !inr);
        check("done_rdata", rdata[u], last_rd[u]);
        got = rdata[u];
    endtask

    initial begin
        logic [31:0] got;
        int          u;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; rw_[k] = 1'b1; addr[k] = '0; wdata[k] = '0; be[k] = '0;
        end
        init_model();

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_rdata", rdata[k], 32'h0);
            check("rst_ready", ready[k], 1'b0);
            check("rst_busy", busy[k], 1'b0);
            check("rst_err", err[k], 1'b0);
        end
        @(negedge clock);
        reset = 1'b0;
        idle(1);

        // Boot image read back with two wait states
        for (int i = 0; i < 10; i++) begin
            do_access(0, 1'b1, AW'(i), $urandom, NB'($urandom), 1'b0, got);
            check("boot_image", got, boot(i));
        end
        idle(1);

        // Byte-lane write, then an all-lanes-disabled write
        do_access(0, 1'b0, 12'd12, 32'hDEADBEEF, 4'b0101, 1'b0, got);
        do_access(0, 1'b1, 12'd12, 32'h0, 4'hF, 1'b0, got);
        check("be_0101", got, 32'h00AD00EF);
        do_access(0, 1'b0, 12'd12, 32'h13579BDF, 4'b0000, 1'b0, got);
        do_access(0, 1'b1, 12'd12, 32'h0, 4'h0, 1'b0, got);
        check("be_0000", got, 32'h00AD00EF);
        idle(1);

        // Zero wait states, request held high: one access every 2 cycles
        for (int i = 0; i < 4; i++) begin
            do_access(1, 1'b1, AW'(i), $urandom, NB'($urandom), 1'b1, got);
            check("held_read", got, boot(i));
        end
        @(negedge clock);
        req[1] = 1'b0;
        idle(2);

        // Reset in the middle of a write to word 5
        @(negedge clock);
        req[0] = 1'b1; rw_[0] = 1'b0; addr[0] = 12'd5; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
        @(posedge clock); #1;
        req[0] = 1'b0;
        check("abort_busy", busy[0], 1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_busy_cleared", busy[0], 1'b0);
        @(negedge clock);
        reset = 1'b0;
        init_model();
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            check("abort_no_ready", ready[0], 1'b0);
            check("abort_rdata", rdata[0], 32'h0);
        end
        do_access(0, 1'b1, 12'd5, 32'h0, 4'h0, 1'b0, got);
        check("abort_word5", got, 32'h18000007);
        idle(1);

        // Addresses at and beyond DEPTH
        do_access(0, 1'b1, 12'd40, 32'h0, 4'h0, 1'b0, got);
        do_access(0, 1'b0, 12'd40, 32'hA5A5A5A5, 4'hF, 1'b0, got);
        do_access(0, 1'b1, 12'd8, 32'h0, 4'h0, 1'b0, got);
        do_access(0, 1'b0, 12'd33, 32'h12345678, 4'hF, 1'b0, got);
        do_access(0, 1'b1, 12'd1, 32'h0, 4'h0, 1'b0, got);
`ifdef MEM_RANGE_CHECK_EN
        check("addr33_word1", got, 32'h20009000);
`else
        check("addr33_word1", got, 32'h12345678);
`endif
        do_access(1, 1'b1, 12'd31, 32'h0, 4'h0, 1'b0, got);
        idle(1);

        // Randomized traffic on both units
        for (int n = 0; n < 80; n++) begin
            u = $urandom_range(0, 1);
            do_access(u, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 47)),
                      $urandom, NB'($urandom), 1'b0, got);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
